// File: rtl/nn_fixed_pkg.sv
// Shared Q16.16 fixed-point constants and the neuron accumulator state encoding.
package nn_fixed_pkg;

    localparam int          FRAC_W = 16;
    localparam logic [31:0] Q_ONE  = 32'h0001_0000;
    localparam logic [31:0] Q_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN  = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        BIAS,
        OUT
    } state_e;

endpackage

// File: rtl/sat_add32.sv
// Combinational 32-bit two's-complement adder that clamps to Q_MAX/Q_MIN on overflow.
module sat_add32
    import nn_fixed_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        sat
);

    logic [31:0] rawSum;

    // Overflow is only possible when both operands share a sign and the result flips it.
    always_comb begin
        rawSum = a + b;
        sat    = (a[31] == b[31]) && (rawSum[31] != a[31]);
        if (sat) begin
            sum = a[31] ? Q_MIN : Q_MAX;
        end else begin
            sum = rawSum;
        end
    end

endmodule

// File: rtl/neuron_accumulator.sv
// Sums N_INPUTS Q16.16 products plus a bias into a saturating accumulator, one activation per neuron.
// Define NEURON_RELU_EN to clamp negative activations to zero on the way out.
module neuron_accumulator
    import nn_fixed_pkg::*;
#(
    parameter int N_INPUTS = 784,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [DATA_W-1:0] prod_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              sat_flag
);

    localparam int                CNT_W    = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_INPUTS - 1);

    state_e            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       bias_q, bias_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              sat_q, sat_d;

    logic [31:0]       addB;
    logic [31:0]       addSum;
    logic              addSat;

    // A single adder serves both the product stream and the final bias add.
    assign addB = (state_q == BIAS) ? bias_q : prod_data;

    sat_add32 u_sat_add (
        .a   (acc_q),
        .b   (addB),
        .sum (addSum),
        .sat (addSat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            bias_q     <= '0;
            out_data_q <= '0;
            count_q    <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            bias_q     <= bias_d;
            out_data_q <= out_data_d;
            count_q    <= count_d;
            sat_q      <= sat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        bias_d     = bias_q;
        out_data_d = out_data_q;
        count_d    = count_q;
        sat_d      = sat_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bias_d  = bias;
                    acc_d   = '0;
                    count_d = '0;
                    sat_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (prod_valid) begin
                    acc_d   = addSum;
                    sat_d   = sat_q | addSat;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_IDX) begin
                        state_d = BIAS;
                    end
                end
            end
            BIAS: begin
                acc_d = addSum;
                sat_d = sat_q | addSat;
`ifdef NEURON_RELU_EN
                out_data_d = addSum[31] ? 32'h0 : addSum;
`else
                out_data_d = addSum;
`endif
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign prod_ready = (state_q == ACCUM);
    assign out_valid  = (state_q == OUT);
    assign busy       = (state_q != IDLE);
    assign out_data   = out_data_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator with N_INPUTS=4; honours NEURON_RELU_EN for the ReLU case.
module tb_neuron_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] bias;
    logic        prod_valid;
    logic        prod_ready;
    logic [31:0] prod_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        sat_flag;

    int checks   = 0;
    int failures = 0;
    int accepts  = 0;

    neuron_accumulator #(.N_INPUTS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bias       (bias),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (prod_valid && prod_ready) accepts <= accepts + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [31:0] b, input logic pv,
                                 input logic [31:0] pd, input logic ordy);
        start      = st;
        bias       = b;
        prod_valid = pv;
        prod_data  = pd;
        out_ready  = ordy;
    endtask

    task automatic sendProduct(input logic [31:0] p, input int gap);
        for (int g = 0; g < gap; g++) begin
            applyStimulus(1'b0, bias, 1'b0, 32'hDEAD_BEEF, 1'b0);
            tick();
        end
        checkOutput("prod_ready_in_accum", {31'b0, prod_ready}, 32'd1);
        applyStimulus(1'b0, bias, 1'b1, p, 1'b0);
        tick();
        applyStimulus(1'b0, bias, 1'b0, 32'h0, 1'b0);
    endtask

    // Leaves the DUT sitting in OUT with out_ready low.
    task automatic runNeuron(input logic [31:0] b, input logic [31:0] p0, input logic [31:0] p1,
                             input logic [31:0] p2, input logic [31:0] p3, input int maxGap);
        applyStimulus(1'b1, b, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
        sendProduct(p0, (maxGap > 0) ? $urandom_range(maxGap, 0) : 0);
        sendProduct(p1, (maxGap > 0) ? $urandom_range(maxGap, 0) : 0);
        sendProduct(p2, (maxGap > 0) ? $urandom_range(maxGap, 0) : 0);
        sendProduct(p3, (maxGap > 0) ? $urandom_range(maxGap, 0) : 0);
        checkOutput("bias_cycle_ready", {31'b0, prod_ready}, 32'd0);
        checkOutput("bias_cycle_valid", {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput("out_latency", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic finishOut();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("idle_after_handshake", {31'b0, busy}, 32'd0);
        checkOutput("valid_after_handshake", {31'b0, out_valid}, 32'd0);
    endtask

    logic [31:0] heldData;
    int          acceptsBefore;

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #12;
        checkOutput("reset_prod_ready", {31'b0, prod_ready}, 32'd0);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_sat", {31'b0, sat_flag}, 32'd0);
        checkOutput("reset_out_data", out_data, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Case 1: 1.0 + 2.0 + 0.5 - 0.5 + bias 1.0 = 4.0
        runNeuron(32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_8000, 0);
        checkOutput("basic_sum", out_data, 32'h0004_0000);
        checkOutput("basic_sat", {31'b0, sat_flag}, 32'd0);
        finishOut();

        // Case 2: positive overflow clamps and stays clamped
        runNeuron(32'h0, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 0);
        checkOutput("overflow_sum", out_data, 32'h7FFF_FFFF);
        checkOutput("overflow_sat", {31'b0, sat_flag}, 32'd1);
        finishOut();
        checkOutput("sat_sticky_in_idle", {31'b0, sat_flag}, 32'd1);
        applyStimulus(1'b1, 32'h0001_0000, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("sat_cleared_on_start", {31'b0, sat_flag}, 32'd0);
        sendProduct(32'h0001_0000, 0);
        sendProduct(32'h0002_0000, 0);
        sendProduct(32'h0000_8000, 0);
        sendProduct(32'hFFFF_8000, 0);
        tick();
        checkOutput("after_overflow_sum", out_data, 32'h0004_0000);
        checkOutput("after_overflow_sat", {31'b0, sat_flag}, 32'd0);
        finishOut();

        // Case 3: -1 -1 -1 + 0 = -3.0
        runNeuron(32'h0, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0, 0);
`ifdef NEURON_RELU_EN
        checkOutput("relu_negative", out_data, 32'h0000_0000);
`else
        checkOutput("raw_negative", out_data, 32'hFFFD_0000);
`endif
        checkOutput("negative_sat", {31'b0, sat_flag}, 32'd0);
        finishOut();

        // Case 4: hold OUT under backpressure, stray start ignored
        runNeuron(32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_8000, 0);
        heldData = out_data;
        checkOutput("bp_initial_data", heldData, 32'h0004_0000);
        for (int c = 0; c < 5; c++) begin
            applyStimulus((c == 2), 32'h1234_0000, 1'b1, 32'h0001_0000, 1'b0);
            tick();
            checkOutput("bp_data_stable", out_data, 32'h0004_0000);
            checkOutput("bp_prod_ready", {31'b0, prod_ready}, 32'd0);
            checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
        end
        applyStimulus(1'b1, 32'h1234_0000, 1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("bp_same_cycle_start_ignored", {31'b0, busy}, 32'd0);
        checkOutput("bp_valid_dropped", {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput("bp_still_idle", {31'b0, busy}, 32'd0);

        // Case 5: reset in the middle of accumulation
        applyStimulus(1'b1, 32'h0001_0000, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        sendProduct(32'h4000_0000, 0);
        sendProduct(32'h4000_0000, 0);
        rst = 1'b1;
        #1;
        checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
        checkOutput("midreset_prod_ready", {31'b0, prod_ready}, 32'd0);
        checkOutput("midreset_out_data", out_data, 32'h0);
        checkOutput("midreset_sat", {31'b0, sat_flag}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("postreset_busy", {31'b0, busy}, 32'd0);
        checkOutput("postreset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("postreset_out_data", out_data, 32'h0);
        runNeuron(32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_8000, 0);
        checkOutput("postreset_sum", out_data, 32'h0004_0000);
        finishOut();

        // Case 6: bubbles between products
        acceptsBefore = accepts;
        runNeuron(32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_8000, 3);
        checkOutput("bubble_sum", out_data, 32'h0004_0000);
        checkOutput("bubble_accepts", accepts - acceptsBefore, 32'd4);
        finishOut();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
